operand_fetch: RTL and testbench

Operand fetch stage sitting directly upstream of the dual-read-port `Memory_Unit`. It accepts read requests carrying two word addresses and drives the memory's `A1`/`A2` ports from a registered address stage. On the following cycle it captures the combinational `D1`/`D2` read data into a 3-entry output FIFO, so the stage sustains one request per cycle under backpressure. It pairs each operand with the request tag for the downstream execute logic.

---
 rtl/operand_fetch_pkg.sv | 25 ++
 rtl/operand_fetch_fifo.sv | 64 ++++++
 rtl/operand_fetch.sv | 112 +++++++++++
 tb/tb_operand_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths, FIFO geometry and entry layout for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_TAG_W  = 4;
  localparam int unsigned FIFO_DEPTH = 3;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned COUNT_W    = 2;
  localparam int unsigned STAT_W     = 16;

  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] d1;
    logic [DEF_DATA_W-1:0] d2;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // Circular pointer advance over a non-power-of-two depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/operand_fetch_fifo.sv
// Three-entry synchronous FIFO with occupancy count; a push into a full FIFO
// is accepted when the same edge pops.
module operand_fetch_fifo
  import operand_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [COUNT_W-1:0] count,
  output logic               empty
);

  logic [WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [COUNT_W-1:0] count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign do_pop_s  = pop && (count_r != {COUNT_W{1'b0}});
  assign do_push_s = push && ((count_r != COUNT_W'(FIFO_DEPTH)) || do_pop_s);

  // Storage array; cleared on reset so the idle head presents zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {COUNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(COUNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {COUNT_W{1'b0}});

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: registered address stage driving a dual-read memory,
// read data captured into a 3-entry FIFO under credit-based flow control.
// Optional OPERAND_FETCH_STATS_EN adds saturating accept/stall counters.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_a1,
  input  logic [ADDR_W-1:0] req_a2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ADDR_W-1:0] mem_a1,
  output logic [ADDR_W-1:0] mem_a2,
  input  logic [DATA_W-1:0] mem_d1,
  input  logic [DATA_W-1:0] mem_d2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_d1,
  output logic [DATA_W-1:0] out_d2,
  output logic [TAG_W-1:0]  out_tag
`ifdef OPERAND_FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_accepts,
  output logic [STAT_W-1:0] stat_stalls
`endif
);

  localparam int unsigned EW = TAG_W + 2 * DATA_W;

  logic              s1_valid_r;
  logic [ADDR_W-1:0] a1_r;
  logic [ADDR_W-1:0] a2_r;
  logic [TAG_W-1:0]  tag_r;
  logic [COUNT_W-1:0] count_s;
  logic [2:0]        occ_s;
  logic              accept_s;
  logic              empty_s;
  logic [EW-1:0]     head_s;

  // Credit check uses registered state only, so out_ready never reaches req_ready.
  assign occ_s     = {1'b0, count_s} + {2'b00, s1_valid_r};
  assign req_ready = (occ_s < 3'd3) && !rst;
  assign accept_s  = req_valid && req_ready;

  // Address stage; addresses hold their last value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      a1_r       <= {ADDR_W{1'b0}};
      a2_r       <= {ADDR_W{1'b0}};
      tag_r      <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      a1_r       <= req_a1;
      a2_r       <= req_a2;
      tag_r      <= req_tag;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  assign mem_a1 = a1_r;
  assign mem_a2 = a2_r;

  operand_fetch_fifo #(
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid_r),
    .push_data ({tag_r, mem_d1, mem_d2}),
    .pop       (out_valid && out_ready),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  assign out_valid = !empty_s;
  assign out_tag   = head_s[EW-1 -: TAG_W];
  assign out_d1    = head_s[2*DATA_W-1 -: DATA_W];
  assign out_d2    = head_s[DATA_W-1:0];

`ifdef OPERAND_FETCH_STATS_EN
  logic [STAT_W-1:0] stat_accepts_r;
  logic [STAT_W-1:0] stat_stalls_r;

  // Saturating activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_accepts_r <= {STAT_W{1'b0}};
      stat_stalls_r  <= {STAT_W{1'b0}};
    end else begin
      if (accept_s && (stat_accepts_r != {STAT_W{1'b1}})) begin
        stat_accepts_r <= stat_accepts_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      if (req_valid && !req_ready && (stat_stalls_r != {STAT_W{1'b1}})) begin
        stat_stalls_r <= stat_stalls_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_accepts = stat_accepts_r;
  assign stat_stalls  = stat_stalls_r;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural dual-read memory.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [8:0] req_a1;
  logic [8:0] req_a2;
  logic [3:0] req_tag;
  logic [8:0] mem_a1;
  logic [8:0] mem_a2;
  logic [9:0] mem_d1;
  logic [9:0] mem_d2;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_d1;
  logic [9:0] out_d2;
  logic [3:0] out_tag;
`ifdef OPERAND_FETCH_STATS_EN
  logic [15:0] stat_accepts;
  logic [15:0] stat_stalls;
`endif

  logic [9:0] mem_arr [512];
  entry_t     sb [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         accepts = 0;
  int         pops = 0;
  logic       last_accept = 1'b0;
  logic       rand_ready = 1'b0;

  assign mem_d1 = mem_arr[mem_a1];
  assign mem_d2 = mem_arr[mem_a2];

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a1    (req_a1),
    .req_a2    (req_a2),
    .req_tag   (req_tag),
    .mem_a1    (mem_a1),
    .mem_a2    (mem_a2),
    .mem_d1    (mem_d1),
    .mem_d2    (mem_d2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_tag   (out_tag)
`ifdef OPERAND_FETCH_STATS_EN
    ,
    .stat_accepts (stat_accepts),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Monitor: handshakes are sampled on the falling edge ahead of the edge that commits them.
  initial forever begin
    entry_t e;
    @(negedge clk);
    last_accept = req_valid && req_ready;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("out_d1", 32'(out_d1), 32'(e.d1));
        check_eq("out_d2", 32'(out_d2), 32'(e.d2));
        check_eq("out_tag", 32'(out_tag), 32'(e.tag));
        pops++;
      end
    end
    if (!rst && req_valid && req_ready) begin
      sb.push_back('{tag: req_tag, d1: mem_arr[req_a1], d2: mem_arr[req_a2]});
      accepts++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_one(input logic [8:0] a1, input logic [8:0] a2, input logic [3:0] tg);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_a1 = a1;
    req_a2 = a2;
    req_tag = tg;
    do begin
      step();
      n++;
    end while (!last_accept && n < 50);
    check_eq("accept_in_budget", 32'(last_accept), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    check_eq("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    sb.delete();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int acc0;
    int pop0;
    for (int i = 0; i < 512; i++) mem_arr[i] = 10'($urandom);
    mem_arr[9'h005] = 10'h2AA;
    mem_arr[9'h1FF] = 10'h155;
    rst = 1'b1;
    req_valid = 1'b0;
    req_a1 = 9'd0;
    req_a2 = 9'd0;
    req_tag = 4'd0;
    out_ready = 1'b1;
    #3;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_d1", 32'(out_d1), 32'd0);
    check_eq("rst_mem_a1", 32'(mem_a1), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("ready_after_release", 32'(req_ready), 32'd1);

    // Single request latency
    req_valid = 1'b1;
    req_a1 = 9'h005;
    req_a2 = 9'h1FF;
    req_tag = 4'd3;
    step();
    check_eq("single_accepted", 32'(last_accept), 32'd1);
    check_eq("single_mem_a1", 32'(mem_a1), 32'h005);
    check_eq("single_valid_early", 32'(out_valid), 32'd0);
    req_valid = 1'b0;
    step();
    check_eq("single_valid", 32'(out_valid), 32'd1);
    check_eq("single_d1", 32'(out_d1), 32'h2AA);
    check_eq("single_d2", 32'(out_d2), 32'h155);
    check_eq("single_tag", 32'(out_tag), 32'd3);
    step();
    check_eq("mem_a_hold", 32'(mem_a2), 32'h1FF);
    drain(3);

    // Back-to-back with out_ready high
    pop0 = pops;
    for (int i = 0; i < 20; i++) begin
      send_one(9'($urandom), 9'($urandom), 4'(i));
      if (i >= 1) check_eq("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    step();
    step();
    check_eq("b2b_pops", 32'(pops - pop0), 32'd20);
    drain(3);

    // Credit limit with out_ready low
    out_ready = 1'b0;
    acc0 = accepts;
    req_valid = 1'b1;
    req_a1 = 9'($urandom);
    req_a2 = 9'($urandom);
    req_tag = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_accept) begin
        req_a1 = 9'($urandom);
        req_a2 = 9'($urandom);
        req_tag = 4'($urandom);
      end
    end
    check_eq("credit_accepts", 32'(accepts - acc0), 32'd3);
    check_eq("credit_ready_low", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("credit_ready_after_pop", 32'(req_ready), 32'd1);
    step();
    check_eq("credit_reaccept", 32'(last_accept), 32'd1);
    drain(6);

    // Random backpressure
    rand_ready = 1'b1;
    acc0 = accepts;
    for (int i = 0; i < 200; i++) send_one(9'($urandom), 9'($urandom), 4'(i));
    check_eq("rand_accepts", 32'(accepts - acc0), 32'd200);
    drain(6);

    // Reset with two entries held
    out_ready = 1'b0;
    send_one(9'($urandom), 9'($urandom), 4'd1);
    send_one(9'($urandom), 9'($urandom), 4'd2);
    step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_d1", 32'(out_d1), 32'd0);
    check_eq("mid_rst_d2", 32'(out_d2), 32'd0);
    check_eq("mid_rst_tag", 32'(out_tag), 32'd0);
    check_eq("mid_rst_mem_a2", 32'(mem_a2), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    out_ready = 1'b1;
    pop0 = pops;
    send_one(9'h005, 9'h1FF, 4'd9);
    step();
    step();
    check_eq("post_rst_pops", 32'(pops - pop0), 32'd1);
    drain(3);

`ifdef OPERAND_FETCH_STATS_EN
    do_reset();
    out_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_a1 = 9'($urandom);
      req_a2 = 9'($urandom);
      step();
    end
    req_valid = 1'b0;
    drain(6);
    send_one(9'($urandom), 9'($urandom), 4'd4);
    send_one(9'($urandom), 9'($urandom), 4'd5);
    step();
    check_eq("stat_accepts", 32'(stat_accepts), 32'd5);
    check_eq("stat_stalls", 32'(stat_stalls), 32'd4);
    out_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 65529; i++) step();
    req_valid = 1'b0;
    step();
    check_eq("stat_preload", 32'(stat_accepts), 32'hFFFE);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    req_valid = 1'b0;
    step();
    check_eq("stat_saturate", 32'(stat_accepts), 32'hFFFF);
    drain(4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
